// File: rtl/dda_pkg.sv
// Shared constants and types for the DDA state-frame UART transmitter.
// FRAME_CHECKSUM_EN selects an 8-byte frame with a trailing XOR checksum;
// without it frames are 7 bytes and no checksum logic exists.
package dda_pkg;

   // First byte of every frame, used by the receiver to find frame boundaries.
   localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef FRAME_CHECKSUM_EN
   localparam int FRAME_BYTES = 8;
`else
   localparam int FRAME_BYTES = 7;
`endif

   // Index of the final byte of a frame.
   localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

   // Serial line state: one START/DATA/STOP pass per byte, IDLE between frames.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 byte serialiser. A byte is loaded when start is high in IDLE or in the
// final cycle of a stop bit; done pulses in that final stop-bit cycle so the
// caller can chain the next byte with no idle gap.
//
// Handshake: start/data are sampled only in IDLE or while done is high; a byte
// presented at any other time is ignored. done is a single-cycle pulse.
module uart_tx_core
   import dda_pkg::*;
#(
   parameter int BIT_CYC = 1250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       done
);

   localparam int            CW       = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYC - 1);

   tx_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          bit_end;

   // Last cycle of the current bit period.
   assign bit_end = (cnt_q == CNT_LAST);
   assign tx      = tx_q;

   // State, timing and line registers; reset drives the line idle-high.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   // Next-state logic: the line value for the next bit is registered on the
   // boundary so tx changes exactly one cycle after the decision.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start) begin
               state_d = START;
               tx_d    = 1'b0;
               shift_d = data;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               cnt_d   = '0;
               bit_d   = '0;
               tx_d    = shift_q[0];
               shift_d = {1'b0, shift_q[7:1]};
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  tx_d    = shift_q[0];
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               done  = 1'b1;
               cnt_d = '0;
               if (start) begin
                  state_d = START;
                  tx_d    = 1'b0;
                  shift_d = data;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/dda_frame_tx.sv
// Decimating telemetry framer for DDA state words. Every DECIM-th integration
// step captures x/y/z into a snapshot and sends it over UART as
// A5, xh, xl, yh, yl, zh, zl [, checksum]. Captures that arrive while a frame
// is in flight are counted in drops (saturating), except one landing in the
// final stop-bit cycle, which starts the next frame back-to-back.
// Optional feature macro: FRAME_CHECKSUM_EN (adds XOR checksum byte).
module dda_frame_tx
   import dda_pkg::*;
#(
   parameter int N         = 16,
   parameter int CLK_FREQ  = 12000000,
   parameter int BAUD_RATE = 9600,
   parameter int DECIM     = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic [N-1:0] z,
   output logic         tx,
   output logic         busy,
   output logic [7:0]   drops
);

   localparam int            BIT_CYC  = CLK_FREQ / BAUD_RATE;
   localparam int            DW       = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [DW-1:0] DEC_LAST = DW'(DECIM - 1);

   logic [DW-1:0] dec_cnt_q, dec_cnt_d;
   logic [N-1:0]  snap_x_q, snap_x_d;
   logic [N-1:0]  snap_y_q, snap_y_d;
   logic [N-1:0]  snap_z_q, snap_z_d;
   logic [2:0]    byte_idx_q, byte_idx_d;
   logic          busy_q, busy_d;
   logic [7:0]    drops_q, drops_d;

   logic       cap_req;
   logic       frame_end;
   logic       next_byte;
   logic       accept;
   logic       core_start;
   logic [7:0] core_data;
   logic       core_tx;
   logic       core_done;
   logic [2:0] next_idx;
   logic [7:0] byte_sel;

`ifdef FRAME_CHECKSUM_EN
   logic [7:0] csum;
   // Checksum covers the six payload bytes of the held snapshot.
   assign csum = snap_x_q[N-1:N-8] ^ snap_x_q[7:0] ^
                 snap_y_q[N-1:N-8] ^ snap_y_q[7:0] ^
                 snap_z_q[N-1:N-8] ^ snap_z_q[7:0];
`endif

   // A step that wraps the decimation counter requests a capture.
   assign cap_req   = en && (dec_cnt_q == DEC_LAST);
   // done in the last byte marks the final stop-bit cycle of the frame.
   assign frame_end = core_done && (byte_idx_q == LAST_BYTE);
   assign next_byte = core_done && !frame_end;
   // Accept when idle, or exactly at frame end for back-to-back frames.
   assign accept    = cap_req && (!busy_q || frame_end);
   assign next_idx  = byte_idx_q + 3'd1;

   assign core_start = accept || next_byte;
   assign core_data  = accept ? SYNC_BYTE : byte_sel;

   assign tx    = core_tx;
   assign busy  = busy_q;
   assign drops = drops_q;

   // Select the payload byte that follows the one currently on the line.
   always_comb begin
      byte_sel = SYNC_BYTE;
      case (next_idx)
         3'd1:    byte_sel = snap_x_q[N-1:N-8];
         3'd2:    byte_sel = snap_x_q[7:0];
         3'd3:    byte_sel = snap_y_q[N-1:N-8];
         3'd4:    byte_sel = snap_y_q[7:0];
         3'd5:    byte_sel = snap_z_q[N-1:N-8];
         3'd6:    byte_sel = snap_z_q[7:0];
`ifdef FRAME_CHECKSUM_EN
         3'd7:    byte_sel = csum;
`endif
         default: byte_sel = SYNC_BYTE;
      endcase
   end

   // Decimation, snapshot capture, byte sequencing and drop accounting.
   always_comb begin
      dec_cnt_d  = dec_cnt_q;
      snap_x_d   = snap_x_q;
      snap_y_d   = snap_y_q;
      snap_z_d   = snap_z_q;
      byte_idx_d = byte_idx_q;
      busy_d     = busy_q;
      drops_d    = drops_q;

      if (en) begin
         dec_cnt_d = (dec_cnt_q == DEC_LAST) ? '0 : dec_cnt_q + 1'b1;
      end

      if (accept) begin
         snap_x_d   = x;
         snap_y_d   = y;
         snap_z_d   = z;
         byte_idx_d = '0;
         busy_d     = 1'b1;
      end else if (frame_end) begin
         busy_d = 1'b0;
      end else if (next_byte) begin
         byte_idx_d = next_idx;
      end

      if (cap_req && !accept && (drops_q != 8'hFF)) begin
         drops_d = drops_q + 8'd1;
      end
   end

   // Registers; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         dec_cnt_q  <= '0;
         snap_x_q   <= '0;
         snap_y_q   <= '0;
         snap_z_q   <= '0;
         byte_idx_q <= '0;
         busy_q     <= 1'b0;
         drops_q    <= '0;
      end else begin
         dec_cnt_q  <= dec_cnt_d;
         snap_x_q   <= snap_x_d;
         snap_y_q   <= snap_y_d;
         snap_z_q   <= snap_z_d;
         byte_idx_q <= byte_idx_d;
         busy_q     <= busy_d;
         drops_q    <= drops_d;
      end
   end

   uart_tx_core #(
      .BIT_CYC (BIT_CYC)
   ) u_core (
      .clk   (clk),
      .rst   (rst),
      .start (core_start),
      .data  (core_data),
      .tx    (core_tx),
      .done  (core_done)
   );

endmodule

// File: doc/dda_frame_tx.md
DDA_FRAME_TX -- requirements
Module: dda_frame_tx

Interface
REQ-001 Parameter N, default 16: width of each state word (posit16, ES=1).
REQ-002 Parameter CLK_FREQ, default 12000000: clk frequency in Hz.
REQ-003 Parameter BAUD_RATE, default 9600: serial bit rate.
REQ-004 Parameter DECIM, default 64: one frame per DECIM integration steps.
REQ-005 The block SHALL use clock clk and reset rst, with rst synchronous and active-high.
REQ-006 clk  input  1  system clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 en  input  1  integration-step strobe from the DDA, one-cycle pulse per step.
REQ-009 x, y, z  input  N each  current DDA state words.
REQ-010 tx  output  1  UART serial line, 8N1, idle high.
REQ-011 busy  output  1  high while a frame is in flight.
REQ-012 drops  output  8  count of decimated samples lost because busy was high.

Function
REQ-013 A decimation counter SHALL increment on each en pulse, wrapping from DECIM-1 to 0; the pulse that wraps it is a capture request.
REQ-014 On a capture request with busy low, the block SHALL latch x, y, z into a snapshot register in that cycle and raise busy the next cycle.
REQ-015 On a capture request with busy high, the block SHALL discard the sample, keep the snapshot unchanged, and increment drops, saturating at 255.
REQ-016 Exception: a capture request in the final cycle of the last stop bit SHALL be accepted, giving back-to-back frames.
REQ-017 Frame byte order SHALL be 0xA5, x[15:8], x[7:0], y[15:8], y[7:0], z[15:8], z[7:0], then the checksum byte when enabled.
REQ-018 Each byte SHALL be sent as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1).
REQ-019 Each bit SHALL last BIT_CYC = CLK_FREQ/BAUD_RATE cycles, using integer division; 1250 at the default parameters.
REQ-020 Bytes within a frame SHALL follow with no idle gap.
REQ-021 FSM states SHALL be IDLE, START, DATA, STOP:
- IDLE->START on an accepted capture.
- START->DATA after BIT_CYC.
- DATA->STOP after 8 bits.
- STOP->START if bytes remain or a new capture is accepted; otherwise STOP->IDLE.
REQ-022 tx SHALL fall for the start bit exactly 1 cycle after the capture cycle.
REQ-023 busy SHALL be low only in IDLE.
REQ-024 State inputs SHALL be ignored outside the capture cycle; the snapshot is immutable during a frame.

Reset
REQ-025 On rst, the block SHALL set tx=1, busy=0, drops=0, the decimation counter to 0, the bit/byte counters to 0, the snapshot to 0, and the FSM to IDLE.
REQ-026 A reset mid-frame SHALL abort the frame, with tx high from the next cycle and no partial resumption.
REQ-027 An en pulse coincident with rst SHALL be ignored.

Configuration
REQ-028 With FRAME_CHECKSUM_EN defined, each frame SHALL carry 8 bytes, the last being the XOR of bytes 1..6.
REQ-029 Without FRAME_CHECKSUM_EN, each frame SHALL carry 7 bytes, and the checksum logic SHALL be absent.

Structure
REQ-030 Package dda_pkg SHALL hold SYNC_BYTE (0xA5), FRAME_BYTES (7 or 8, per macro), and the FSM state enum tx_state_t.
REQ-031 The bit-timing shifter SHALL be a sub-module uart_tx_core with ports clk, rst, start, data[7:0], tx, done; dda_frame_tx SHALL hold the decimation logic, snapshot, byte sequencing and drop counter.

Verification
REQ-032 Bench parameters SHALL be CLK_FREQ=16, BAUD_RATE=1, DECIM=4, with FRAME_CHECKSUM_EN defined.
REQ-033 Basic frame: x=0xC000, y=0x14CD, z=0x7240, 4 en pulses -> decoded bytes A5 C0 00 14 CD 72 40 2B; frame spans 8*10*16=1280 cycles; busy high for exactly 1280 cycles.
REQ-034 Decimation: 3 en pulses -> tx stays 1 and busy stays 0; the 4th pulse -> start bit 1 cycle later.
REQ-035 Overrun: 8 en pulses inside one frame -> drops=2, frame content unchanged; 1100 further decimated overruns -> drops saturates at 255.
REQ-036 Back-to-back: capture in the final stop-bit cycle -> second frame starts with no idle cycle and drops unchanged.
REQ-037 Mid-frame reset: rst asserted at cycle 500 of a frame -> tx=1 and busy=0 next cycle; the next capture produces a complete, correct frame.
REQ-038 Without FRAME_CHECKSUM_EN: same stimulus as REQ-033 -> 7 bytes with no 0x2B; busy high for 1120 cycles.
